// File: rtl/ram_ctrl_pkg.sv
`default_nettype none
// ==========================================================================
// Package : ram_ctrl_pkg
// Shared defaults and types for the two-port RAM front end.
// Rev     : 1.0
// ==========================================================================
package ram_ctrl_pkg;

  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DATA_W = 16;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  typedef logic port_id_t;

endpackage
`default_nettype wire

// File: rtl/ram_port_arbiter_if.sv
`default_nettype none
// ==========================================================================
// Interface : ram_port_arbiter_if
// Request/response bundle shared by the two requesters and the arbiter.
// Rev       : 1.0
// ==========================================================================
interface ram_port_arbiter_if
  import ram_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic [1:0]        req_valid;
  logic [1:0]        req_write;
  logic [ADDR_W-1:0] req_addr0;
  logic [ADDR_W-1:0] req_addr1;
  logic [DATA_W-1:0] req_wdata0;
  logic [DATA_W-1:0] req_wdata1;
  logic [1:0]        req_ready;
  logic [1:0]        rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;

  modport master (
    output req_valid, req_write, req_addr0, req_addr1, req_wdata0, req_wdata1,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr0, req_addr1, req_wdata0, req_wdata1,
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ==========================================================================
// Module : rr_arb2
// Two-way round-robin grant with a registered one-bit priority pointer.
// Rev    : 1.0
// ==========================================================================
module rr_arb2
  import ram_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       enable,
  input  logic       advance,
  output logic [1:0] gnt
);

  port_id_t r_ptr;

  always_comb begin
    gnt = 2'b00;
    if (enable) begin
      if (req == 2'b11) gnt = r_ptr ? 2'b10 : 2'b01;
      else              gnt = req;
    end
  end

  // After a grant, preference passes to the port that was not served.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         r_ptr <= 1'b0;
    else if (advance) r_ptr <= ~gnt[1];
  end

endmodule
`default_nettype wire

// File: rtl/ram_port_arbiter.sv
`default_nettype none
// ==========================================================================
// Module : ram_port_arbiter
// Clears the RAM after reset, then shares it between two requesters.
// Rev    : 1.0
// ==========================================================================
module ram_port_arbiter
  import ram_ctrl_pkg::*;
#(
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int RD_LAT         = 1,
  parameter int CLEAR_ON_RESET = 1
)(
  input  logic               clk,
  input  logic               rst,
  ram_port_arbiter_if.slave  bus,
  output logic               init_done,
  output logic               ram_wr_en,
  output logic               ram_rd_en,
  output logic               ram_blk_select,
  output logic [ADDR_W-1:0]  ram_addr_wr,
  output logic [ADDR_W-1:0]  ram_addr_rd,
  output logic [DATA_W-1:0]  ram_din,
  input  logic [DATA_W-1:0]  ram_dout
);

  localparam logic [0:0]        c_st_init   = ST_INIT;
  localparam logic [0:0]        c_st_run    = ST_RUN;
  localparam logic [0:0]        c_st_reset  = (CLEAR_ON_RESET != 0) ? c_st_init : c_st_run;
  localparam logic [ADDR_W-1:0] c_last_addr = '1;

  logic [0:0]        r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_iss_wr;
  logic              r_iss_rd;
  logic [ADDR_W-1:0] r_iss_addr;
  logic [DATA_W-1:0] r_iss_data;
  port_id_t          r_iss_port;
  logic [RD_LAT-1:0] r_pv;
  logic [RD_LAT-1:0] r_pt;

  logic       w_init;
  logic       w_run;
  logic [1:0] w_gnt;
  logic       w_acc;
  port_id_t   w_sel;

  // Qualify with rst so every output reads zero while reset is held.
  assign w_init = (r_state == c_st_init) && rst;
  assign w_run  = (r_state == c_st_run)  && rst;
  assign w_acc  = |w_gnt;
  assign w_sel  = w_gnt[1];

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (bus.req_valid),
    .enable  (w_run),
    .advance (w_acc),
    .gnt     (w_gnt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= c_st_reset;
      r_cnt   <= '0;
    end else if (r_state == c_st_init) begin
      if (r_cnt == c_last_addr) r_state <= c_st_run;
      else                      r_cnt   <= r_cnt + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_iss_wr   <= 1'b0;
      r_iss_rd   <= 1'b0;
      r_iss_addr <= '0;
      r_iss_data <= '0;
      r_iss_port <= 1'b0;
    end else begin
      r_iss_wr <= w_acc &  bus.req_write[w_sel];
      r_iss_rd <= w_acc & ~bus.req_write[w_sel];
      if (w_acc) begin
        r_iss_addr <= w_sel ? bus.req_addr1  : bus.req_addr0;
        r_iss_data <= w_sel ? bus.req_wdata1 : bus.req_wdata0;
        r_iss_port <= w_sel;
      end
    end
  end

  // Read tags travel alongside the RAM's read latency.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pv <= '0;
      r_pt <= '0;
    end else begin
      r_pv <= (r_pv << 1) | RD_LAT'(r_iss_rd);
      r_pt <= (r_pt << 1) | RD_LAT'(r_iss_port);
    end
  end

  assign ram_wr_en      = w_init | r_iss_wr;
  assign ram_rd_en      = r_iss_rd;
  assign ram_blk_select = ram_wr_en | ram_rd_en;
  assign ram_addr_wr    = w_init ? r_cnt : r_iss_addr;
  assign ram_addr_rd    = r_iss_addr;
  assign ram_din        = w_init ? '0 : r_iss_data;

  assign init_done     = w_run;
  assign bus.req_ready = w_gnt;
  assign bus.rsp_valid = {r_pv[RD_LAT-1] &  r_pt[RD_LAT-1],
                          r_pv[RD_LAT-1] & ~r_pt[RD_LAT-1]};
  assign bus.rsp_rdata = rst ? ram_dout : '0;

endmodule
`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
`default_nettype none
// ==========================================================================
// Module : tb_ram_port_arbiter
// Self-checking bench: RAM model plus transaction-level reference model.
// Rev    : 1.0
// ==========================================================================
module tb_ram_port_arbiter;

  localparam int AW     = 10;
  localparam int DW     = 16;
  localparam int DEPTH  = 1 << AW;
  localparam int RD_LAT = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  ram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  ram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_nc ();

  logic          init_done, ram_wr_en, ram_rd_en, ram_blk_select;
  logic [AW-1:0] ram_addr_wr, ram_addr_rd;
  logic [DW-1:0] ram_din, ram_dout;

  logic          nc_init_done, nc_ram_wr_en, nc_ram_rd_en, nc_ram_blk_select;
  logic [AW-1:0] nc_ram_addr_wr, nc_ram_addr_rd;
  logic [DW-1:0] nc_ram_din;
  logic [DW-1:0] nc_ram_dout = '0;

  ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RD_LAT), .CLEAR_ON_RESET(1)) dut (
    .clk(clk), .rst(rst), .bus(bus), .init_done(init_done),
    .ram_wr_en(ram_wr_en), .ram_rd_en(ram_rd_en), .ram_blk_select(ram_blk_select),
    .ram_addr_wr(ram_addr_wr), .ram_addr_rd(ram_addr_rd),
    .ram_din(ram_din), .ram_dout(ram_dout)
  );

  ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RD_LAT), .CLEAR_ON_RESET(0)) dut_nc (
    .clk(clk), .rst(rst), .bus(bus_nc), .init_done(nc_init_done),
    .ram_wr_en(nc_ram_wr_en), .ram_rd_en(nc_ram_rd_en), .ram_blk_select(nc_ram_blk_select),
    .ram_addr_wr(nc_ram_addr_wr), .ram_addr_rd(nc_ram_addr_rd),
    .ram_din(nc_ram_din), .ram_dout(nc_ram_dout)
  );

  // Behavioural RAM: starts full of garbage so the clear is observable.
  logic [DW-1:0] ram_mem [DEPTH];
  bit            fill_done = 1'b0;
  always @(posedge clk) begin
    if (!fill_done) begin
      for (int i = 0; i < DEPTH; i++) ram_mem[i] <= DW'($urandom);
      ram_dout  <= 16'hDEAD;
      fill_done <= 1'b1;
    end else begin
      if (ram_blk_select && ram_wr_en) ram_mem[ram_addr_wr] <= ram_din;
      if (ram_blk_select && ram_rd_en) ram_dout <= ram_mem[ram_addr_rd];
    end
  end

  // Reference contents and arbitration preference of the model.
  logic [DW-1:0] ref_mem [DEPTH];
  logic          m_pref;

  task automatic drive(input logic [1:0] v, input logic [1:0] w,
                       input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                       input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    bus.req_valid  = v;  bus.req_write  = w;
    bus.req_addr0  = a0; bus.req_addr1  = a1;
    bus.req_wdata0 = d0; bus.req_wdata1 = d1;
  endtask

  task automatic test_reset();
    int errs, first_bad, nc_errs, nz;
    errs = 0; first_bad = -1; nc_errs = 0; nz = 0;
    rst = 1'b0;
    drive(2'b11, 2'b00, '0, '0, '0, '0);
    bus_nc.req_valid = 2'b11; bus_nc.req_write = 2'b00;
    bus_nc.req_addr0 = '0; bus_nc.req_addr1 = '0; bus_nc.req_wdata0 = '0; bus_nc.req_wdata1 = '0;
    repeat (3) @(negedge clk);
    #1;
    n_tests++; if ({ram_wr_en, ram_rd_en, ram_blk_select, init_done} !== 4'b0 || ram_addr_wr !== '0 || ram_addr_rd !== '0 || ram_din !== '0) begin
      n_fail++; $display("FAIL rst_ram_outputs: got wr%b rd%b blk%b done%b aw%h ar%h din%h, want all 0", ram_wr_en, ram_rd_en, ram_blk_select, init_done, ram_addr_wr, ram_addr_rd, ram_din); end
    n_tests++; if (bus.req_ready !== 2'b00 || bus.rsp_valid !== 2'b00 || bus.rsp_rdata !== '0) begin
      n_fail++; $display("FAIL rst_bus_outputs: got ready %b rsp %b rdata %h, want 0", bus.req_ready, bus.rsp_valid, bus.rsp_rdata); end
    n_tests++; if (nc_init_done !== 1'b0 || bus_nc.req_ready !== 2'b00) begin
      n_fail++; $display("FAIL rst_nc_outputs: got done %b ready %b, want 0 00", nc_init_done, bus_nc.req_ready); end

    @(negedge clk); rst = 1'b1; #1;
    n_tests++; if (nc_init_done !== 1'b1 || bus_nc.req_ready !== 2'b01) begin
      n_fail++; $display("FAIL nc_first_cycle: got done %b ready %b, want 1 01", nc_init_done, bus_nc.req_ready); end
    bus_nc.req_valid = 2'b00;

    for (int k = 0; k < DEPTH; k++) begin
      if (k != 0) begin @(negedge clk); #1; end
      if (ram_wr_en !== 1'b1 || ram_rd_en !== 1'b0 || ram_addr_wr !== AW'(k) || ram_din !== '0 ||
          bus.req_ready !== 2'b00 || init_done !== 1'b0) begin
        errs++; if (first_bad < 0) first_bad = k;
      end
      if (nc_ram_wr_en !== 1'b0) nc_errs++;
    end
    n_tests++; if (errs != 0) begin
      n_fail++; $display("FAIL init_sequence: got %0d bad cycles (first %0d), want 0", errs, first_bad); end
    n_tests++; if (nc_errs != 0) begin
      n_fail++; $display("FAIL nc_no_init_writes: got %0d write cycles, want 0", nc_errs); end

    @(negedge clk); #1;
    n_tests++; if (init_done !== 1'b1 || ram_wr_en !== 1'b0 || bus.req_ready !== 2'b01) begin
      n_fail++; $display("FAIL init_done_edge: got done %b wr %b ready %b, want 1 0 01", init_done, ram_wr_en, bus.req_ready); end
    bus.req_valid = 2'b00;

    for (int i = 0; i < DEPTH; i++) begin
      if (ram_mem[i] !== '0) nz++;
      ref_mem[i] = '0;
    end
    n_tests++; if (nz != 0) begin
      n_fail++; $display("FAIL ram_cleared: got %0d nonzero words, want 0", nz); end
  endtask

  task automatic test_contention();
    logic [1:0] exp_rdy, exp_rsp;
    logic [DW-1:0] exp_d;
    @(negedge clk); drive(2'b01, 2'b01, 10'h010, '0, 16'hA5A5, '0); #1;
    n_tests++; if (bus.req_ready !== 2'b01) begin
      n_fail++; $display("FAIL ct_setup_wr0: got ready %b want 01", bus.req_ready); end
    @(negedge clk); drive(2'b10, 2'b10, '0, 10'h020, '0, 16'h5A5A); #1;
    n_tests++; if (bus.req_ready !== 2'b10) begin
      n_fail++; $display("FAIL ct_setup_wr1: got ready %b want 10", bus.req_ready); end
    ref_mem[10'h010] = 16'hA5A5;
    ref_mem[10'h020] = 16'h5A5A;

    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      if (k < 4) drive(2'b11, 2'b00, 10'h010, 10'h020, '0, '0);
      else       drive(2'b00, 2'b00, '0, '0, '0, '0);
      #1;
      if (k < 4) begin
        exp_rdy = (k % 2 == 0) ? 2'b01 : 2'b10;
        n_tests++; if (bus.req_ready !== exp_rdy) begin
          n_fail++; $display("FAIL ct_grant[%0d]: got %b want %b", k, bus.req_ready, exp_rdy); end
      end
      exp_rsp = 2'b00; exp_d = '0;
      if (k >= 2 && k < 6) begin
        exp_rsp = ((k - 2) % 2 == 0) ? 2'b01 : 2'b10;
        exp_d   = ((k - 2) % 2 == 0) ? 16'hA5A5 : 16'h5A5A;
      end
      n_tests++; if (bus.rsp_valid !== exp_rsp || (exp_rsp != 2'b00 && bus.rsp_rdata !== exp_d)) begin
        n_fail++; $display("FAIL ct_rsp[%0d]: got %b/%h want %b/%h", k, bus.rsp_valid, bus.rsp_rdata, exp_rsp, exp_d); end
    end
  endtask

  task automatic test_single_port();
    @(negedge clk); drive(2'b01, 2'b01, 10'h005, '0, 16'hBEEF, '0); #1;
    n_tests++; if (bus.req_ready !== 2'b01) begin
      n_fail++; $display("FAIL sp_wr_ready: got %b want 01", bus.req_ready); end
    @(negedge clk); drive(2'b01, 2'b00, 10'h005, '0, '0, '0); #1;
    n_tests++; if (ram_wr_en !== 1'b1 || ram_rd_en !== 1'b0 || ram_blk_select !== 1'b1 || ram_addr_wr !== 10'h005 || ram_din !== 16'hBEEF) begin
      n_fail++; $display("FAIL sp_ram_write: got wr%b rd%b blk%b a%h d%h want 1 0 1 005 beef", ram_wr_en, ram_rd_en, ram_blk_select, ram_addr_wr, ram_din); end
    n_tests++; if (bus.req_ready !== 2'b01) begin
      n_fail++; $display("FAIL sp_rd_ready: got %b want 01", bus.req_ready); end
    ref_mem[10'h005] = 16'hBEEF;
    @(negedge clk); drive(2'b00, 2'b00, '0, '0, '0, '0); #1;
    n_tests++; if (ram_rd_en !== 1'b1 || ram_wr_en !== 1'b0 || ram_addr_rd !== 10'h005 || bus.rsp_valid !== 2'b00) begin
      n_fail++; $display("FAIL sp_ram_read: got rd%b wr%b a%h rsp%b want 1 0 005 00", ram_rd_en, ram_wr_en, ram_addr_rd, bus.rsp_valid); end
    @(negedge clk); #1;
    n_tests++; if (bus.rsp_valid !== 2'b01 || bus.rsp_rdata !== 16'hBEEF) begin
      n_fail++; $display("FAIL sp_rsp: got %b/%h want 01/beef", bus.rsp_valid, bus.rsp_rdata); end
    @(negedge clk); #1;
    n_tests++; if (bus.rsp_valid !== 2'b00) begin
      n_fail++; $display("FAIL sp_rsp_single: got %b want 00", bus.rsp_valid); end
  endtask

  task automatic test_write_then_read();
    @(negedge clk); drive(2'b10, 2'b10, '0, 10'h3FF, '0, 16'h1234); #1;
    n_tests++; if (bus.req_ready !== 2'b10) begin
      n_fail++; $display("FAIL wtr_wr_ready: got %b want 10", bus.req_ready); end
    @(negedge clk); drive(2'b01, 2'b00, 10'h3FF, '0, '0, '0); #1;
    n_tests++; if (bus.req_ready !== 2'b01 || ram_wr_en !== 1'b1 || ram_addr_wr !== 10'h3FF || ram_din !== 16'h1234) begin
      n_fail++; $display("FAIL wtr_rd_accept: got ready %b wr%b a%h d%h want 01 1 3ff 1234", bus.req_ready, ram_wr_en, ram_addr_wr, ram_din); end
    ref_mem[10'h3FF] = 16'h1234;
    @(negedge clk); drive(2'b00, 2'b00, '0, '0, '0, '0); #1;
    @(negedge clk); #1;
    n_tests++; if (bus.rsp_valid !== 2'b01 || bus.rsp_rdata !== 16'h1234) begin
      n_fail++; $display("FAIL wtr_rsp: got %b/%h want 01/1234", bus.rsp_valid, bus.rsp_rdata); end
    // Grants so far end on port 0, so port 1 is now preferred.
    m_pref = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [1:0]    pend, pw, eg, exp_rsp;
    logic [AW-1:0] pa [2];
    logic [DW-1:0] pd [2];
    logic          ew, er, gp;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed, exp_d;
    int            q_due [$];
    logic          q_port [$];
    logic [DW-1:0] q_data [$];
    int            t;
    pend = 2'b00; pw = 2'b00; ew = 1'b0; er = 1'b0; ea = '0; ed = '0; t = 0;
    pa[0] = '0; pa[1] = '0; pd[0] = '0; pd[1] = '0;
    while (t < 400 && (t < 200 || pend != 2'b00 || q_due.size() != 0 || ew || er)) begin
      @(negedge clk);
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && t < 200 && $urandom_range(0, 3) != 0) begin
          pend[p] = 1'b1;
          pw[p]   = 1'($urandom_range(0, 1));
          pa[p]   = ($urandom_range(0, 3) != 0) ? AW'($urandom_range(0, 15)) : AW'($urandom_range(0, DEPTH - 1));
          pd[p]   = DW'($urandom);
        end
      end
      drive(pend, pw, pa[0], pa[1], pd[0], pd[1]);
      #1;
      case (pend)
        2'b01:   eg = 2'b01;
        2'b10:   eg = 2'b10;
        2'b11:   eg = m_pref ? 2'b10 : 2'b01;
        default: eg = 2'b00;
      endcase
      n_tests++; if (bus.req_ready !== eg) begin
        n_fail++; $display("FAIL b2b_grant[%0d]: got %b want %b", t, bus.req_ready, eg); end
      n_tests++; if (ram_wr_en !== ew || ram_rd_en !== er || ram_blk_select !== (ew | er) ||
                     (ew && (ram_addr_wr !== ea || ram_din !== ed)) || (er && ram_addr_rd !== ea)) begin
        n_fail++; $display("FAIL b2b_cmd[%0d]: got wr%b rd%b aw%h ar%h d%h want wr%b rd%b a%h d%h",
                           t, ram_wr_en, ram_rd_en, ram_addr_wr, ram_addr_rd, ram_din, ew, er, ea, ed); end
      exp_rsp = 2'b00; exp_d = '0;
      if (q_due.size() != 0 && q_due[0] == t) begin
        exp_rsp = q_port[0] ? 2'b10 : 2'b01;
        exp_d   = q_data[0];
        void'(q_due.pop_front()); void'(q_port.pop_front()); void'(q_data.pop_front());
      end
      n_tests++; if (bus.rsp_valid !== exp_rsp || (exp_rsp != 2'b00 && bus.rsp_rdata !== exp_d)) begin
        n_fail++; $display("FAIL b2b_rsp[%0d]: got %b/%h want %b/%h", t, bus.rsp_valid, bus.rsp_rdata, exp_rsp, exp_d); end
      ew = 1'b0; er = 1'b0;
      if (eg != 2'b00) begin
        gp = eg[1];
        ea = pa[gp];
        if (pw[gp]) begin
          ew = 1'b1; ed = pd[gp]; ref_mem[ea] = ed;
        end else begin
          er = 1'b1;
          q_due.push_back(t + 1 + RD_LAT); q_port.push_back(gp); q_data.push_back(ref_mem[ea]);
        end
        pend[gp] = 1'b0;
        m_pref   = ~gp;
      end
      t++;
    end
    drive(2'b00, 2'b00, '0, '0, '0, '0);
    n_tests++; if (pend != 2'b00 || q_due.size() != 0) begin
      n_fail++; $display("FAIL b2b_drain: got pending %b, %0d responses outstanding, want none", pend, q_due.size()); end
  endtask

  task automatic test_mid_read_reset();
    @(negedge clk); drive(2'b01, 2'b00, 10'h005, '0, '0, '0); #1;
    n_tests++; if (bus.req_ready !== 2'b01) begin
      n_fail++; $display("FAIL mrr_accept: got %b want 01", bus.req_ready); end
    @(negedge clk); drive(2'b00, 2'b00, '0, '0, '0, '0); #1;
    n_tests++; if (ram_rd_en !== 1'b1) begin
      n_fail++; $display("FAIL mrr_issue: got rd %b want 1", ram_rd_en); end
    rst = 1'b0; #1;
    n_tests++; if (ram_rd_en !== 1'b0 || bus.rsp_valid !== 2'b00) begin
      n_fail++; $display("FAIL mrr_in_reset: got rd %b rsp %b want 0 00", ram_rd_en, bus.rsp_valid); end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); #1;
      n_tests++; if (bus.rsp_valid !== 2'b00) begin
        n_fail++; $display("FAIL mrr_no_rsp[%0d]: got %b want 00", k, bus.rsp_valid); end
    end
    @(negedge clk); rst = 1'b1; #1;
    n_tests++; if (ram_wr_en !== 1'b1 || ram_addr_wr !== '0 || init_done !== 1'b0 || bus.rsp_valid !== 2'b00) begin
      n_fail++; $display("FAIL mrr_init_restart: got wr%b a%h done%b rsp%b want 1 000 0 00", ram_wr_en, ram_addr_wr, init_done, bus.rsp_valid); end
    @(negedge clk); #1;
    n_tests++; if (ram_wr_en !== 1'b1 || ram_addr_wr !== 10'h001 || bus.rsp_valid !== 2'b00) begin
      n_fail++; $display("FAIL mrr_init_next: got wr%b a%h rsp%b want 1 001 00", ram_wr_en, ram_addr_wr, bus.rsp_valid); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    m_pref = 1'b0;
    test_reset();
    test_contention();
    test_single_port();
    test_write_then_read();
    test_back_to_back();
    test_mid_read_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Two-requester front end for the single-bank 1024x16 `Ram` block. After reset it clears the whole array to zero, then shares the RAM's write and read ports between two independent requesters. Each requester uses a valid/ready request handshake and gets a per-port read-response strobe. It sits directly in front of `Ram` and drives every RAM control input; no other logic touches the RAM.

## Interface
Parameters:
- `ADDR_W`, 10, RAM address width; depth = 2**ADDR_W
- `DATA_W`, 16, data width
- `RD_LAT`, 1, RAM read latency in cycles from `ram_rd_en` to valid `ram_dout` (≥1)
- `CLEAR_ON_RESET`, 1, 1 = zero-fill the RAM after reset; 0 = skip directly to RUN

Ports:
- `clk`  in  1  single clock, all logic on the rising edge
- `rst`  in  1  asynchronous, active-low reset
- `req_valid[1:0]`  in  2  per-port request valid
- `req_write[1:0]`  in  2  per-port: 1 = write, 0 = read
- `req_addr0`, `req_addr1`  in  ADDR_W  request address
- `req_wdata0`, `req_wdata1`  in  DATA_W  write data
- `req_ready[1:0]`  out  2  per-port grant; a transfer occurs when valid & ready at the clock edge
- `rsp_valid[1:0]`  out  2  per-port one-cycle read-data strobe
- `rsp_rdata`  out  DATA_W  read data, shared; meaningful only while a `rsp_valid` bit is high
- `init_done`  out  1  high once clearing has finished
- `ram_wr_en`, `ram_rd_en`, `ram_blk_select`  out  1  RAM controls
- `ram_addr_wr`, `ram_addr_rd`  out  ADDR_W  RAM addresses
- `ram_din`  out  DATA_W  RAM write data
- `ram_dout`  in  DATA_W  RAM read data

## Operation
- **FSM states:** INIT and RUN.
  - Reset enters INIT if `CLEAR_ON_RESET` = 1, otherwise RUN.
  - INIT → RUN after the write to address DEPTH-1 is issued. RUN is terminal until the next reset.
- **INIT:**
  - A counter runs 0..DEPTH-1, one write per cycle: `ram_wr_en` = 1, `ram_addr_wr` = count, `ram_din` = 0.
  - `req_ready` = 0 throughout INIT.
- **RUN arbitration (round-robin, two ports):**
  - A one-bit priority pointer gives preference to one port.
  - If only one port is valid, that port is granted.
  - If both are valid, the preferred port is granted.
  - After any grant, the pointer moves to the other port. With no grant, the pointer holds.
  - At most one request is accepted per cycle.
  - `req_ready` is combinational from `req_valid`, the FSM state and the pointer. It is never asserted for a port whose `req_valid` is low.
- **Issue:** an accepted request is registered and presented to the RAM in the following cycle.
  - Write: `ram_wr_en` = 1 with `ram_addr_wr` and `ram_din` set from the request.
  - Read: `ram_rd_en` = 1 with `ram_addr_rd` set from the request.
  - Only one of `ram_wr_en` / `ram_rd_en` is ever high in a given cycle.
  - `ram_blk_select` = `ram_wr_en` | `ram_rd_en`.
- **Response:**
  - A port-ID pipeline of depth `RD_LAT` tracks in-flight reads.
  - `rsp_valid[p]` pulses for one cycle exactly when `ram_dout` holds that read's data.
  - `rsp_rdata` = `ram_dout`.
  - Responses have no backpressure; requesters must take them.
- **Ordering:** all commands reach the RAM in acceptance order. A write accepted before a read to the same address makes the read return the new data.

## Timing
- **Reset values** (while `rst` = 0): all outputs 0, pointer = port 0, INIT counter = 0, in-flight pipeline cleared.
- **Reset mid-operation:** in-flight reads are dropped and produce no `rsp_valid`. INIT restarts from address 0.
- **INIT timing:** the first INIT write is in the first cycle after `rst` deasserts. Writes occupy DEPTH consecutive cycles. `init_done` rises the cycle after the last INIT write, and `req_ready` may assert in that same cycle.
- **Write latency:** accepted at edge N → RAM write during cycle N+1.
- **Read latency:** accepted at edge N → `rsp_valid` during cycle N+1+`RD_LAT` (2 cycles for the default).
- **Throughput:** one accepted request per cycle, back-to-back, with any read/write mix.
- **Address wrap:** none. Addresses are ADDR_W bits and always in range. The INIT counter stops at DEPTH-1 and does not wrap.
- **Request hold:** a requester holds `req_valid`, address and data stable until it sees `req_ready`. The block samples them only at the accepting edge.

## Structure
- **Package `ram_ctrl_pkg`:**
  - `ADDR_W` / `DATA_W` defaults
  - state enum {`ST_INIT`, `ST_RUN`}
  - port-ID type (1 bit)
- **Sub-module `rr_arb2`:** combinational two-way round-robin grant plus the registered pointer. Inputs: `req[1:0]`, `enable`, `advance`. Output: `gnt[1:0]`.
- **Top level:** FSM, INIT counter, issue register, read-tag pipeline.

## Test plan
- **Reset/INIT:** release `rst` → `ram_wr_en` high for exactly 1024 cycles, addresses 0..1023, `ram_din` = 0; `init_done` rises next cycle; `req_ready` = 0 throughout.
- **Single port:** port 0 writes addr 0x005 data 0xBEEF, then reads 0x005 → RAM write one cycle after acceptance; `rsp_valid[0]` two cycles after the read is accepted, `rsp_rdata` = 0xBEEF; `rsp_valid[1]` stays 0.
- **Contention:** both ports hold valid for 4 cycles, port 0 reading 0x010 and port 1 reading 0x020 → grants alternate 0,1,0,1; responses are routed to the matching `rsp_valid` bit in the same order.
- **Write-then-read ordering:** port 1 writes 0x3FF = 0x1234 and port 0 then reads 0x3FF in the next cycle → port 0 receives 0x1234.
- **Mid-read reset:** assert `rst` one cycle after a read is accepted → no `rsp_valid` appears; INIT restarts at address 0.
- **`CLEAR_ON_RESET` = 0:** `init_done` = 1 and `req_ready` is available in the first cycle after reset; no INIT writes occur.
